// File: rtl/apa102_pkg.sv
// -----------------------------------------------------------------------------
// apa102_pkg
// Shared definitions for the APA102 frame streamer: the frame FSM state
// encoding and the fixed APA102 frame geometry.
//   state_e      : IDLE, START_FRAME, FETCH, LED_DATA, END_FRAME, DONE
//   LED_HDR      : 3'b111 marker that opens every LED frame
//   START_BITS   : length of the all-zero start frame
//   PIXEL_W      : width of one RGB word read from the frame buffer
//   LED_FRAME_W  : width of one serialised word (start, LED and end frames)
// -----------------------------------------------------------------------------
package apa102_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_FRAME,
    FETCH,
    LED_DATA,
    END_FRAME,
    DONE
  } state_e;

  localparam logic [2:0] LED_HDR     = 3'b111;
  localparam int         START_BITS  = 32;
  localparam int         PIXEL_W     = 24;
  localparam int         LED_FRAME_W = 32;

endpackage

// File: rtl/apa102_bit_tx.sv
// -----------------------------------------------------------------------------
// apa102_bit_tx
// Serialises one 32-bit word MSB first on a two-wire SPI link. Each bit is
// presented with SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : load word_i; accepted only while ready_o=1
//   word_i     : word to serialise
//   repeat_i   : sampled at the end of bit 31; when high the same word is sent
//                again without a gap (used for multi-word end frames)
//   ready_o    : idle, rises in the cycle after the final SCK falling edge
//   last_o     : high in the final cycle of bit 31 (SCK about to fall)
//   sck_o      : SPI clock, idles low
//   mosi_o     : SPI data, returns to 0 when the transmitter goes idle
// -----------------------------------------------------------------------------
module apa102_bit_tx
  import apa102_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [LED_FRAME_W-1:0] word_i,
  input  logic                   repeat_i,
  output logic                   ready_o,
  output logic                   last_o,
  output logic                   sck_o,
  output logic                   mosi_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(LED_FRAME_W);

  logic                   busy_q;
  logic                   sck_q;
  logic                   mosi_q;
  logic [DIV_W-1:0]       div_q;
  logic [BIT_W-1:0]       bit_q;
  logic [LED_FRAME_W-1:0] shift_q;
  logic                   half_end;
  logic                   accept;

  assign half_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign accept   = load_i && !busy_q;
  assign ready_o  = !busy_q;
  assign last_o   = busy_q && sck_q && half_end && (bit_q == BIT_W'(LED_FRAME_W - 1));
  assign sck_o    = sck_q;
  assign mosi_o   = mosi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
    end else if (accept) begin
      busy_q <= 1'b1;
      sck_q  <= 1'b0;
      mosi_q <= word_i[LED_FRAME_W-1];
      div_q  <= '0;
      bit_q  <= '0;
    end else if (busy_q) begin
      if (!half_end) begin
        div_q <= div_q + 1'b1;
      end else begin
        div_q <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
        end else begin
          sck_q <= 1'b0;
          if (last_o && !repeat_i) begin
            busy_q <= 1'b0;
            mosi_q <= 1'b0;
          end else begin
            // bit_q wraps 31 -> 0 naturally on a repeated word
            bit_q  <= bit_q + 1'b1;
            mosi_q <= shift_q[LED_FRAME_W-2];
          end
        end
      end
    end
  end

  // Rotate rather than shift so that after 32 bits the register holds the
  // original word again, which lets a repeat continue seamlessly.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= word_i;
    end else if (busy_q && sck_q && half_end) begin
      shift_q <= {shift_q[LED_FRAME_W-2:0], shift_q[LED_FRAME_W-1]};
    end
  end

endmodule

// File: rtl/apa102_frame_streamer.sv
// -----------------------------------------------------------------------------
// apa102_frame_streamer
// On a start pulse walks every LED address of the frame-buffer RAM (one-cycle
// read latency) and streams an APA102 frame: 32-bit start frame of zeros, one
// {111, brightness, B, G, R} word per LED, then 32*ceil(NUM_LEDS/64) ones.
// Optional feature macro: APA102_BRIGHTNESS_PORT_EN adds the brightness input,
// latched when start is accepted; otherwise the BRIGHTNESS parameter is used.
// Ports:
//   clk, rst_n  : clock (RAM read clock), synchronous active-low reset
//   start       : begin one frame, sampled only in IDLE
//   busy        : high from the cycle after start acceptance through DONE
//   done        : one-cycle pulse after the last end-frame bit
//   raddr       : RAM read address, changes only on FETCH entry
//   read_data   : RAM word {R, G, B}, valid one cycle after raddr changes
//   brightness  : global 5-bit brightness (macro builds only)
//   spi_sck     : APA102 clock, idles low
//   spi_mosi    : APA102 data, MSB first
// -----------------------------------------------------------------------------
module apa102_frame_streamer
  import apa102_pkg::*;
#(
  parameter  int         NUM_LEDS   = 64,
  parameter  int         CLK_DIV    = 4,
  parameter  logic [4:0] BRIGHTNESS = 5'd31,
  localparam int         ADDR_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [PIXEL_W-1:0] read_data,
`ifdef APA102_BRIGHTNESS_PORT_EN
  input  logic [4:0]         brightness,
`endif
  output logic               spi_sck,
  output logic               spi_mosi
);

  localparam int END_WORDS = (NUM_LEDS + 63) / 64;
  localparam int END_W     = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;

  state_e                 state_q;
  logic [ADDR_W-1:0]      idx_q;
  logic [ADDR_W-1:0]      raddr_q;
  logic [4:0]             bright_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ph_q;
  logic [END_W-1:0]       end_cnt_q;

  logic                   tx_load;
  logic [LED_FRAME_W-1:0] tx_word;
  logic                   tx_repeat;
  logic                   tx_ready;
  logic                   tx_last;
  logic                   last_led;
  logic [4:0]             start_bright;

`ifdef APA102_BRIGHTNESS_PORT_EN
  assign start_bright = brightness;
`else
  assign start_bright = BRIGHTNESS;
`endif

  assign last_led  = (idx_q == ADDR_W'(NUM_LEDS - 1));
  assign tx_repeat = (state_q == END_FRAME) && (end_cnt_q != END_W'(END_WORDS - 1));

  // Word handed to the transmitter: start frame on acceptance, pixel word at
  // the end of FETCH, end-frame ones once the last LED word has drained.
  always_comb begin
    tx_load = 1'b0;
    tx_word = '0;
    case (state_q)
      IDLE: begin
        tx_load = start;
      end
      FETCH: begin
        tx_load = ph_q;
        tx_word = {LED_HDR, bright_q, read_data[7:0], read_data[15:8], read_data[23:16]};
      end
      LED_DATA: begin
        tx_load = tx_ready && last_led;
        tx_word = '1;
      end
      default: ;
    endcase
  end

  // START_FRAME and inner LED words hand off to FETCH on the transmitter's
  // final bit cycle so the two fetch cycles are the only gap per LED; the
  // end frame and DONE wait for ready, costing one cycle each.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      raddr_q   <= '0;
      bright_q  <= BRIGHTNESS;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ph_q      <= 1'b0;
      end_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= START_FRAME;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            bright_q <= start_bright;
          end
        end
        START_FRAME: begin
          if (tx_last) begin
            state_q <= FETCH;
            raddr_q <= idx_q;
            ph_q    <= 1'b0;
          end
        end
        FETCH: begin
          if (!ph_q) begin
            ph_q <= 1'b1;
          end else begin
            state_q <= LED_DATA;
          end
        end
        LED_DATA: begin
          if (last_led) begin
            if (tx_ready) begin
              state_q   <= END_FRAME;
              end_cnt_q <= '0;
            end
          end else if (tx_last) begin
            state_q <= FETCH;
            idx_q   <= idx_q + 1'b1;
            raddr_q <= idx_q + 1'b1;
            ph_q    <= 1'b0;
          end
        end
        END_FRAME: begin
          if (tx_last) begin
            end_cnt_q <= end_cnt_q + 1'b1;
          end
          if (tx_ready) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  apa102_bit_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tx_load),
    .word_i   (tx_word),
    .repeat_i (tx_repeat),
    .ready_o  (tx_ready),
    .last_o   (tx_last),
    .sck_o    (spi_sck),
    .mosi_o   (spi_mosi)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign raddr = raddr_q;

endmodule

// File: tb/tb_apa102_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_apa102_frame_streamer
// Directed bench for apa102_frame_streamer with NUM_LEDS=4, CLK_DIV=2.
// A frame model builds the expected bit stream from the RAM contents; a
// monitor compares every SCK rising edge against it and checks idle levels.
// -----------------------------------------------------------------------------
module tb_apa102_frame_streamer;

  localparam int N         = 4;
  localparam int CD        = 2;
  localparam int END_BITS  = 32 * ((N + 63) / 64);
  localparam int FRAME_CYC = (32 + 32 * N + END_BITS) * 2 * CD + 2 * N + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  raddr;
  logic [23:0] read_data;
  logic        spi_sck;
  logic        spi_mosi;
`ifdef APA102_BRIGHTNESS_PORT_EN
  logic [4:0]  brightness = 5'd31;
`endif

  apa102_frame_streamer #(
    .NUM_LEDS   (N),
    .CLK_DIV    (CD),
    .BRIGHTNESS (5'd31)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .read_data  (read_data),
`ifdef APA102_BRIGHTNESS_PORT_EN
    .brightness (brightness),
`endif
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM; output is X while it still reflects an old address.
  logic [23:0] mem [0:N-1];
  logic [1:0]  rd_addr_q;
  logic [23:0] rd_q;
  always @(posedge clk) begin
    rd_addr_q <= raddr;
    rd_q      <= mem[raddr];
  end
  assign read_data = (rd_addr_q === raddr) ? rd_q : 24'hxxxxxx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame model
  logic exp_q[$];

  function automatic logic [31:0] led_word(input logic [23:0] px, input logic [4:0] br);
    return {3'b111, br, px[7:0], px[15:8], px[23:16]};
  endfunction

  task automatic push_frame(input logic [4:0] br);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) exp_q.push_back(1'b0);
    for (int i = 0; i < N; i++) begin
      w = led_word(mem[i], br);
      for (int b = 31; b >= 0; b--) exp_q.push_back(w[b]);
    end
    for (int b = 0; b < END_BITS; b++) exp_q.push_back(1'b1);
  endtask

  // Monitor
  logic        mon_en = 1'b0;
  logic        prev_sck = 1'b0;
  logic        prev_mosi = 1'b0;
  int          rises = 0;
  int          done_cnt = 0;
  int          done_t [0:7];
  int          busy_low = 0;
  logic [31:0] cap_w [0:15];
  logic [1:0]  cap_a [0:511];

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mosi_known", {31'b0, $isunknown(spi_mosi)}, 32'd0);
      if (busy === 1'b0) begin
        chk("idle_sck", {31'b0, spi_sck}, 32'd0);
        chk("idle_mosi", {31'b0, spi_mosi}, 32'd0);
        busy_low++;
      end
      if (done === 1'b1) begin
        if (done_cnt < 8) done_t[done_cnt] = cyc;
        done_cnt++;
      end
      if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
        chk("mosi_stable", {31'b0, spi_mosi}, {31'b0, prev_mosi});
        if (exp_q.size() == 0) chk("extra_rise", 32'd1, 32'd0);
        else chk("stream_bit", {31'b0, spi_mosi}, {31'b0, exp_q.pop_front()});
        if (rises < 512) cap_a[rises] = raddr;
        if (rises / 32 < 16) cap_w[rises / 32] = {cap_w[rises / 32][30:0], spi_mosi};
        rises++;
      end
      prev_sck  = spi_sck;
      prev_mosi = spi_mosi;
    end
  end

  int t0;

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int k = 0;
    while (done_cnt < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic wait_rises(input int target, input int limit);
    int k = 0;
    while (rises < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (rises < target) chk("rise_timeout", rises, target);
  endtask

  task automatic clear_capture();
    rises = 0;
    done_cnt = 0;
    busy_low = 0;
    exp_q.delete();
  endtask

  task automatic check_addr_hold();
    for (int i = 0; i < N; i++) begin
      int bad = 0;
      for (int b = 0; b < 32; b++)
        if (cap_a[32 + 32 * i + b] !== 2'(i)) bad++;
      chk("raddr_hold", bad, 0);
    end
  endtask

  initial begin
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00FF00;
    mem[2] = 24'h0000FF;
    mem[3] = 24'h123456;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sck", {31'b0, spi_sck}, 32'd0);
    chk("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    chk("rst_raddr", {30'b0, raddr}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    chk("model_word", led_word(mem[3], 5'd31), 32'hFF563412);

    // Single frame
    clear_capture();
    push_frame(5'd31);
    pulse_start();
    wait_done(1, 2000);
    repeat (5) @(posedge clk);
    chk("done_count", done_cnt, 1);
    chk("frame_cycles", done_t[0] - t0, 778);
    chk("frame_model_cycles", done_t[0] - t0, FRAME_CYC);
    chk("rise_count", rises, 192);
    chk("exp_left", exp_q.size(), 0);
    chk("word0", cap_w[0], 32'h00000000);
    chk("word1", cap_w[1], 32'hFF0000FF);
    chk("word2", cap_w[2], 32'hFF00FF00);
    chk("word3", cap_w[3], 32'hFFFF0000);
    chk("word4", cap_w[4], 32'hFF563412);
    chk("word5", cap_w[5], 32'hFFFFFFFF);
    check_addr_hold();

    // start held high: back-to-back frames
    clear_capture();
    push_frame(5'd31);
    push_frame(5'd31);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    busy_low = 0;
    wait_done(2, 4000);
    #1;
    start = 1'b0;
    chk("b2b_busy_low", busy_low, 1);
    repeat (5) @(posedge clk);
    chk("b2b_done_count", done_cnt, 2);
    chk("b2b_first", done_t[0] - t0, 778);
    chk("b2b_gap", done_t[1] - done_t[0], 780);
    chk("b2b_rises", rises, 384);
    chk("b2b_exp_left", exp_q.size(), 0);
    chk("b2b_word6", cap_w[6], 32'h00000000);
    chk("b2b_word10", cap_w[10], 32'hFF563412);

    // Reset in the middle of LED 2
    clear_capture();
    push_frame(5'd31);
    pulse_start();
    wait_rises(100, 1000);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_sck", {31'b0, spi_sck}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("midrst_no_done", done_cnt, 0);
    clear_capture();
    push_frame(5'd31);
    pulse_start();
    wait_done(1, 2000);
    repeat (3) @(posedge clk);
    chk("rerun_cycles", done_t[0] - t0, 778);
    chk("rerun_rises", rises, 192);
    chk("rerun_exp_left", exp_q.size(), 0);
    chk("rerun_word0", cap_w[0], 32'h00000000);
    chk("rerun_word3", cap_w[3], 32'hFFFF0000);
    check_addr_hold();

`ifdef APA102_BRIGHTNESS_PORT_EN
    // Brightness latched at start, later changes ignored
    clear_capture();
    brightness = 5'd3;
    push_frame(5'd3);
    pulse_start();
    wait_rises(40, 1000);
    brightness = 5'd31;
    wait_done(1, 2000);
    repeat (3) @(posedge clk);
    chk("br_exp_left", exp_q.size(), 0);
    for (int i = 1; i <= N; i++) chk("br_header", {24'b0, cap_w[i][31:24]}, 32'hE3);
    chk("br_word4", cap_w[4], 32'hE3563412);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
